sisc_ctrl_seq: RTL and testbench

//  Parametrised multi-cycle control sequencer for the SISC datapath. Decodes opcode/mm/stat
//  and drives PC, IR, register-file, ALU and data-memory controls. Adds over the old FSM:

---
 rtl/sisc_ctrl_seq_if.sv | 39 +++
 rtl/sisc_ctrl_seq.sv | 190 +++++++++++++++++++
 tb/tb_sisc_ctrl_seq.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sisc_ctrl_seq_if.sv
// Control/status bundle between the SISC sequencer and its datapath.
// The master modport is the sequencer side; the slave modport is the datapath side.
interface sisc_ctrl_seq_if #(
    parameter int OPW = 4,
    parameter int CCW = 4
);
    logic [OPW-1:0] opcode;
    logic [CCW-1:0] mm;
    logic [CCW-1:0] stat;
    logic           dm_ack;

    logic           pc_rst;
    logic           pc_write;
    logic           pc_sel;
    logic           br_sel;
    logic           ir_load;
    logic           rf_we;
    logic [1:0]     wb_sel;
    logic [1:0]     alu_op;
    logic           rb_sel;
    logic           swp_sel;
    logic           mm_sel;
    logic           dm_re;
    logic           dm_we;
    logic           halted;
    logic           mem_err;

    modport master (
        input  opcode, mm, stat, dm_ack,
        output pc_rst, pc_write, pc_sel, br_sel, ir_load, rf_we, wb_sel, alu_op,
               rb_sel, swp_sel, mm_sel, dm_re, dm_we, halted, mem_err
    );

    modport slave (
        output opcode, mm, stat, dm_ack,
        input  pc_rst, pc_write, pc_sel, br_sel, ir_load, rf_we, wb_sel, alu_op,
               rb_sel, swp_sel, mm_sel, dm_re, dm_we, halted, mem_err
    );
endinterface

// File: rtl/sisc_ctrl_seq.sv
// Multi-cycle control sequencer for the SISC datapath: fetch/decode/execute with
// short branch paths, req/ack data-memory handshake, optional ack timeout and HALT.
module sisc_ctrl_seq #(
    parameter int OPW         = 4,
    parameter int CCW         = 4,
    parameter int IMM_MM      = 8,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst_f,
    sisc_ctrl_seq_if.master  bus
);

    localparam logic [OPW-1:0] OP_NOOP = OPW'(0);
    localparam logic [OPW-1:0] OP_LOD  = OPW'(1);
    localparam logic [OPW-1:0] OP_STR  = OPW'(2);
    localparam logic [OPW-1:0] OP_SWP  = OPW'(3);
    localparam logic [OPW-1:0] OP_BRA  = OPW'(4);
    localparam logic [OPW-1:0] OP_BRR  = OPW'(5);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(6);
    localparam logic [OPW-1:0] OP_BNR  = OPW'(7);
    localparam logic [OPW-1:0] OP_ALU  = OPW'(8);
    localparam logic [OPW-1:0] OP_HLT  = OPW'(15);

    localparam logic [CCW-1:0] IMM_V       = CCW'(IMM_MM);
    localparam bit             HAS_TIMEOUT = (MEM_TIMEOUT > 0);
    localparam int             CNT_W       = HAS_TIMEOUT ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;

    logic is_imm;
    logic cond_hit;
    logic is_branch_abs;

    assign is_imm        = (bus.mm == IMM_V);
    assign cond_hit      = |(bus.mm & bus.stat);
    assign is_branch_abs = (bus.opcode == OP_BRA) || (bus.opcode == OP_BNE);
    assign bus.mem_err   = mem_err_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; reset is asynchronous and aborts any op.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q    <= S_START;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // NOTE: every output and next-state value gets a default first so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = '0;
        mem_err_d    = mem_err_q;

        bus.pc_rst   = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_sel   = 1'b0;
        bus.br_sel   = 1'b0;
        bus.ir_load  = 1'b0;
        bus.rf_we    = 1'b0;
        bus.wb_sel   = 2'b00;
        bus.alu_op   = 2'b10;
        bus.rb_sel   = 1'b0;
        bus.swp_sel  = 1'b0;
        bus.mm_sel   = 1'b0;
        bus.dm_re    = 1'b0;
        bus.dm_we    = 1'b0;
        bus.halted   = 1'b0;

        unique case (state_q)
            S_START: begin
                bus.pc_rst = 1'b1;
                state_d    = S_FETCH;
            end

            S_FETCH: begin
                bus.ir_load  = 1'b1;
                bus.pc_write = 1'b1;
                state_d      = S_DECODE;
            end

            S_DECODE: begin
                bus.pc_sel = 1'b1;
                bus.br_sel = is_branch_abs;
                // Taken-if-set for BRA/BRR, taken-if-clear for BNE/BNR.
                case (bus.opcode)
                    OP_BRA, OP_BRR: bus.pc_write = cond_hit;
                    OP_BNE, OP_BNR: bus.pc_write = !cond_hit;
                    default:        bus.pc_write = 1'b0;
                endcase
                case (bus.opcode)
                    OP_HLT:                         state_d = S_HALT;
                    OP_ALU, OP_LOD, OP_STR, OP_SWP: state_d = S_EXEC;
                    default:                        state_d = S_FETCH;
                endcase
            end

            S_EXEC: begin
                case (bus.opcode)
                    OP_ALU: begin
                        bus.alu_op = {1'b0, is_imm};
                        state_d    = S_WB;
                    end
                    OP_LOD, OP_STR: begin
                        bus.alu_op = {1'b0, is_imm};
                        state_d    = S_MEM;
                    end
                    OP_SWP:  state_d = S_MEM;
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                case (bus.opcode)
                    OP_LOD, OP_STR: begin
                        bus.rb_sel = 1'b1;
                        bus.mm_sel = !is_imm;
                        bus.dm_re  = (bus.opcode == OP_LOD);
                        bus.dm_we  = (bus.opcode == OP_STR);
                        if (bus.dm_ack) begin
                            // An ack on the timeout cycle still completes normally.
                            if (bus.opcode == OP_LOD) begin
                                bus.rf_we  = 1'b1;
                                bus.wb_sel = 2'b01;
                            end
                            state_d = S_FETCH;
                        end else if (HAS_TIMEOUT && (wait_cnt_q == CNT_LIMIT)) begin
                            mem_err_d = 1'b1;
                            state_d   = S_HALT;
                        end else if (HAS_TIMEOUT) begin
                            wait_cnt_d = wait_cnt_q + CNT_W'(1);
                        end
                    end
                    OP_SWP: begin
                        bus.rb_sel  = 1'b1;
                        bus.swp_sel = 1'b1;
                        bus.rf_we   = 1'b1;
                        bus.wb_sel  = 2'b10;
                        state_d     = S_WB;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_WB: begin
                case (bus.opcode)
                    OP_ALU: begin
                        bus.rf_we  = 1'b1;
                        bus.alu_op = {1'b0, is_imm};
                    end
                    OP_SWP: begin
                        bus.rb_sel = 1'b1;
                        bus.rf_we  = 1'b1;
                        bus.wb_sel = 2'b11;
                    end
                    default: ;
                endcase
                state_d = S_FETCH;
            end

            S_HALT: begin
                bus.halted = 1'b1;
            end

            default: state_d = S_START;
        endcase

        if (OP_NOOP != OP_NOOP) state_d = S_START;
    end

endmodule

// File: tb/tb_sisc_ctrl_seq.sv
// Directed bench for sisc_ctrl_seq: a cycle-by-cycle vector table from reset release,
// then hand-written sequences for ack timeout, HALT hold and asynchronous reset in MEM.
module tb_sisc_ctrl_seq;

    typedef struct packed {
        logic       pc_rst;
        logic       pc_write;
        logic       pc_sel;
        logic       br_sel;
        logic       ir_load;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic [1:0] alu_op;
        logic       rb_sel;
        logic       swp_sel;
        logic       mm_sel;
        logic       dm_re;
        logic       dm_we;
        logic       halted;
        logic       mem_err;
    } ctrl_t;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [3:0] mm;
        logic [3:0] stat;
        logic       ack;
        ctrl_t      exp;
    } vec_t;

    localparam logic [3:0] NOOP = 4'd0, LOD = 4'd1, STR = 4'd2, SWP = 4'd3;
    localparam logic [3:0] BRA = 4'd4, BRR = 4'd5, BNE = 4'd6, BNR = 4'd7;
    localparam logic [3:0] ALU = 4'd8, HLT = 4'd15, UNDEF = 4'd12;

    logic clk;
    logic rst_f;
    int   passed;
    int   total;
    vec_t vecs[$];

    sisc_ctrl_seq_if #(.OPW(4), .CCW(4)) ifc ();

    sisc_ctrl_seq #(
        .OPW(4), .CCW(4), .IMM_MM(8), .MEM_TIMEOUT(4)
    ) dut (
        .clk  (clk),
        .rst_f(rst_f),
        .bus  (ifc.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ctrl_t dflt();
        ctrl_t c;
        c        = '0;
        c.alu_op = 2'b10;
        return c;
    endfunction

    function automatic ctrl_t e_start();
        ctrl_t c = dflt();
        c.pc_rst = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t e_fetch();
        ctrl_t c = dflt();
        c.ir_load  = 1'b1;
        c.pc_write = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t e_dec(input logic pw, input logic bs);
        ctrl_t c = dflt();
        c.pc_sel   = 1'b1;
        c.pc_write = pw;
        c.br_sel   = bs;
        return c;
    endfunction

    function automatic ctrl_t e_alu(input logic [1:0] op);
        ctrl_t c = dflt();
        c.alu_op = op;
        return c;
    endfunction

    function automatic ctrl_t sample();
        ctrl_t c;
        c.pc_rst   = ifc.pc_rst;
        c.pc_write = ifc.pc_write;
        c.pc_sel   = ifc.pc_sel;
        c.br_sel   = ifc.br_sel;
        c.ir_load  = ifc.ir_load;
        c.rf_we    = ifc.rf_we;
        c.wb_sel   = ifc.wb_sel;
        c.alu_op   = ifc.alu_op;
        c.rb_sel   = ifc.rb_sel;
        c.swp_sel  = ifc.swp_sel;
        c.mm_sel   = ifc.mm_sel;
        c.dm_re    = ifc.dm_re;
        c.dm_we    = ifc.dm_we;
        c.halted   = ifc.halted;
        c.mem_err  = ifc.mem_err;
        return c;
    endfunction

    task automatic check(input string name, input ctrl_t got, input ctrl_t exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, got, exp);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic add(input string n, input logic [3:0] op, input logic [3:0] mm,
                       input logic [3:0] stat, input logic ack, input ctrl_t e);
        vec_t v;
        v.name = n; v.op = op; v.mm = mm; v.stat = stat; v.ack = ack; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] mm,
                         input logic [3:0] stat, input logic ack);
        ifc.opcode = op;
        ifc.mm     = mm;
        ifc.stat   = stat;
        ifc.dm_ack = ack;
    endtask

    task automatic fill_table();
        ctrl_t e;
        // ALU register form: reset release to second FETCH is five cycles.
        add("alu_start",  ALU, 4'd0, 4'd0, 1'b0, e_start());
        add("alu_fetch",  ALU, 4'd0, 4'd0, 1'b0, e_fetch());
        add("alu_dec",    ALU, 4'd0, 4'd0, 1'b0, e_dec(1'b0, 1'b0));
        add("alu_exec",   ALU, 4'd0, 4'd0, 1'b0, e_alu(2'b00));
        e = e_alu(2'b00); e.rf_we = 1'b1;
        add("alu_wb",     ALU, 4'd0, 4'd0, 1'b0, e);
        add("alui_fetch", ALU, 4'd8, 4'd0, 1'b1, e_fetch());
        add("alui_dec",   ALU, 4'd8, 4'd0, 1'b0, e_dec(1'b0, 1'b0));
        add("alui_exec",  ALU, 4'd8, 4'd0, 1'b0, e_alu(2'b01));
        e = e_alu(2'b01); e.rf_we = 1'b1;
        add("alui_wb",    ALU, 4'd8, 4'd0, 1'b0, e);
        // Branch short paths.
        add("bra_fetch",  BRA, 4'b0010, 4'b0010, 1'b0, e_fetch());
        add("bra_taken",  BRA, 4'b0010, 4'b0010, 1'b0, e_dec(1'b1, 1'b1));
        add("bra2_fetch", BRA, 4'b0010, 4'b0100, 1'b0, e_fetch());
        add("bra_nt",     BRA, 4'b0010, 4'b0100, 1'b0, e_dec(1'b0, 1'b1));
        add("bnr_fetch",  BNR, 4'b0010, 4'b0010, 1'b0, e_fetch());
        add("bnr_nt",     BNR, 4'b0010, 4'b0010, 1'b0, e_dec(1'b0, 1'b0));
        add("bne_fetch",  BNE, 4'b0001, 4'b0010, 1'b0, e_fetch());
        add("bne_taken",  BNE, 4'b0001, 4'b0010, 1'b0, e_dec(1'b1, 1'b1));
        add("brr_fetch",  BRR, 4'b0011, 4'b0001, 1'b0, e_fetch());
        add("brr_taken",  BRR, 4'b0011, 4'b0001, 1'b0, e_dec(1'b1, 1'b0));
        add("noop_fetch", NOOP, 4'd0, 4'd0, 1'b0, e_fetch());
        add("noop_dec",   NOOP, 4'd0, 4'd0, 1'b0, e_dec(1'b0, 1'b0));
        add("undef_fetch", UNDEF, 4'd0, 4'd0, 1'b0, e_fetch());
        add("undef_dec",  UNDEF, 4'd0, 4'd0, 1'b0, e_dec(1'b0, 1'b0));
        // LOD immediate with three wait states.
        add("lod_fetch",  LOD, 4'd8, 4'd0, 1'b1, e_fetch());
        add("lod_dec",    LOD, 4'd8, 4'd0, 1'b0, e_dec(1'b0, 1'b0));
        add("lod_exec",   LOD, 4'd8, 4'd0, 1'b0, e_alu(2'b01));
        e = dflt(); e.rb_sel = 1'b1; e.dm_re = 1'b1;
        add("lod_wait0",  LOD, 4'd8, 4'd0, 1'b0, e);
        add("lod_wait1",  LOD, 4'd8, 4'd0, 1'b0, e);
        add("lod_wait2",  LOD, 4'd8, 4'd0, 1'b0, e);
        e.rf_we = 1'b1; e.wb_sel = 2'b01;
        add("lod_ack",    LOD, 4'd8, 4'd0, 1'b1, e);
        // STR register-indirect, zero wait.
        add("str_fetch",  STR, 4'd0, 4'd0, 1'b0, e_fetch());
        add("str_dec",    STR, 4'd0, 4'd0, 1'b0, e_dec(1'b0, 1'b0));
        add("str_exec",   STR, 4'd0, 4'd0, 1'b0, e_alu(2'b00));
        e = dflt(); e.rb_sel = 1'b1; e.mm_sel = 1'b1; e.dm_we = 1'b1;
        add("str_ack",    STR, 4'd0, 4'd0, 1'b1, e);
        // SWP two-write sequence.
        add("swp_fetch",  SWP, 4'd0, 4'd0, 1'b0, e_fetch());
        add("swp_dec",    SWP, 4'd0, 4'd0, 1'b0, e_dec(1'b0, 1'b0));
        add("swp_exec",   SWP, 4'd0, 4'd0, 1'b0, dflt());
        e = dflt(); e.rb_sel = 1'b1; e.swp_sel = 1'b1; e.rf_we = 1'b1; e.wb_sel = 2'b10;
        add("swp_mem",    SWP, 4'd0, 4'd0, 1'b0, e);
        e = dflt(); e.rb_sel = 1'b1; e.rf_we = 1'b1; e.wb_sel = 2'b11;
        add("swp_wb",     SWP, 4'd0, 4'd0, 1'b0, e);
        // LOD acked on exactly the timeout cycle completes normally.
        add("lodt_fetch", LOD, 4'd0, 4'd0, 1'b0, e_fetch());
        add("lodt_dec",   LOD, 4'd0, 4'd0, 1'b0, e_dec(1'b0, 1'b0));
        add("lodt_exec",  LOD, 4'd0, 4'd0, 1'b0, e_alu(2'b00));
        e = dflt(); e.rb_sel = 1'b1; e.mm_sel = 1'b1; e.dm_re = 1'b1;
        for (int i = 0; i < 4; i++) add($sformatf("lodt_wait%0d", i), LOD, 4'd0, 4'd0, 1'b0, e);
        e.rf_we = 1'b1; e.wb_sel = 2'b01;
        add("lodt_ack",   LOD, 4'd0, 4'd0, 1'b1, e);
        add("end_fetch",  LOD, 4'd8, 4'd0, 1'b0, e_fetch());
    endtask

    initial begin
        ctrl_t e;
        int    re_cnt;
        int    rf_seen;
        int    hit_halt;

        passed = 0;
        total  = 0;
        rst_f  = 1'b0;
        drive(ALU, 4'd0, 4'd0, 1'b0);
        fill_table();

        @(negedge clk);
        #1 check("reset_state", sample(), e_start());

        @(negedge clk);
        rst_f = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].mm, vecs[i].stat, vecs[i].ack);
            #1 check(vecs[i].name, sample(), vecs[i].exp);
            @(negedge clk);
        end

        // Never-acked LOD: five MEM cycles (counts 0..4), then HALT with mem_err.
        drive(LOD, 4'd8, 4'd0, 1'b0);
        re_cnt = 0; rf_seen = 0; hit_halt = 0;
        for (int i = 0; i < 20 && hit_halt == 0; i++) begin
            #1;
            if (ifc.dm_re) re_cnt++;
            if (ifc.rf_we) rf_seen++;
            if (ifc.halted) hit_halt = 1;
            else @(negedge clk);
        end
        check_int("timeout_reached_halt", hit_halt, 1);
        check_int("timeout_dm_re_cycles", re_cnt, 5);
        check_int("timeout_no_rf_we", rf_seen, 0);
        e = dflt(); e.halted = 1'b1; e.mem_err = 1'b1;
        check("timeout_halt_state", sample(), e);
        @(negedge clk);
        ifc.dm_ack = 1'b1;
        #1 check("timeout_halt_sticky", sample(), e);
        #2 rst_f = 1'b0;
        #1 check("timeout_reset_clears", sample(), e_start());

        // HLT enters HALT after DECODE and holds against changing inputs.
        @(negedge clk);
        rst_f = 1'b1;
        drive(HLT, 4'd0, 4'd0, 1'b0);
        #1 check("hlt_start", sample(), e_start());
        @(negedge clk);
        #1 check("hlt_fetch", sample(), e_fetch());
        @(negedge clk);
        #1 check("hlt_dec", sample(), e_dec(1'b0, 1'b0));
        @(negedge clk);
        e = dflt(); e.halted = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            #1 check($sformatf("hlt_hold%0d", i), sample(), e);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a MEM wait.
        rst_f = 1'b0;
        @(negedge clk);
        rst_f = 1'b1;
        drive(LOD, 4'd0, 4'd0, 1'b0);
        repeat (4) @(negedge clk);
        e = dflt(); e.rb_sel = 1'b1; e.mm_sel = 1'b1; e.dm_re = 1'b1;
        #1 check("arst_in_mem", sample(), e);
        #2 rst_f = 1'b0;
        #1 check("arst_immediate", sample(), e_start());
        ifc.dm_ack = 1'b1;
        @(negedge clk);
        #1 check("arst_late_ack", sample(), e_start());
        rst_f = 1'b1;
        #1 check("arst_release", sample(), e_start());
        @(negedge clk);
        #1 check("arst_fetch", sample(), e_fetch());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
